// File: rtl/ddr3_cmd_arbiter.sv
// Round-robin arbiter sharing the DDR3 app command port between the write and readout controllers.
// Optional statistics counters are built only when DDR3_ARB_STATS_EN is defined.
module ddr3_cmd_arbiter #(
  parameter int ADDR_W  = 26,
  parameter int MAX_RUN = 64,
  parameter int HOLD    = 4,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_app_en,
  input  logic [ADDR_W-1:0] wr_app_addr,
  output logic              wr_app_rdy,
  input  logic              rd_app_en,
  input  logic [ADDR_W-1:0] rd_app_addr,
  output logic              rd_app_rdy,
  output logic              app_en,
  output logic [2:0]        app_cmd,
  output logic [ADDR_W-1:0] app_addr,
  input  logic              app_rdy,
  output logic              grant_wr,
  output logic              grant_rd,
  output logic [CNT_W-1:0]  wr_cmd_cnt,
  output logic [CNT_W-1:0]  rd_cmd_cnt,
  output logic [CNT_W-1:0]  switch_cnt
);

  localparam int RUN_W  = $clog2(MAX_RUN + 1);
  localparam int IDLE_W = $clog2(HOLD + 1);
  localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(MAX_RUN);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(HOLD - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_WR   = 3'b010,
    ST_RD   = 3'b100
  } state_e;

  state_e             state_q, state_d;
  logic [RUN_W-1:0]   run_q, run_d, runNext;
  logic [IDLE_W-1:0]  idle_q, idle_d;
  logic               lastRd_q, lastRd_d;
  logic               ownerWr, ownEn, peerEn, accept;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      run_q    <= '0;
      idle_q   <= '0;
      lastRd_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      run_q    <= run_d;
      idle_q   <= idle_d;
      lastRd_q <= lastRd_d;
    end
  end

  always_comb begin
    app_en     = 1'b0;
    app_cmd    = 3'b000;
    app_addr   = '0;
    wr_app_rdy = 1'b0;
    rd_app_rdy = 1'b0;
    unique case (state_q)
      ST_WR: begin
        app_en     = wr_app_en;
        app_addr   = wr_app_addr;
        wr_app_rdy = app_rdy;
      end
      ST_RD: begin
        app_en     = rd_app_en;
        app_cmd    = 3'b001;
        app_addr   = rd_app_addr;
        rd_app_rdy = app_rdy;
      end
      default: ;
    endcase
  end

  assign grant_wr = (state_q == ST_WR);
  assign grant_rd = (state_q == ST_RD);
  assign ownerWr  = grant_wr;
  assign ownEn    = ownerWr ? wr_app_en : rd_app_en;
  assign peerEn   = ownerWr ? rd_app_en : wr_app_en;
  assign accept   = app_en & app_rdy;

  // A held command (en=1, rdy=0) freezes the state; a run-limit yield may coincide with the final accept.
  always_comb begin
    state_d  = state_q;
    run_d    = run_q;
    idle_d   = idle_q;
    lastRd_d = lastRd_q;
    runNext  = run_q;
    unique case (state_q)
      ST_IDLE: begin
        if (wr_app_en && rd_app_en) begin
          state_d = lastRd_q ? ST_WR : ST_RD;
        end else if (wr_app_en) begin
          state_d = ST_WR;
        end else if (rd_app_en) begin
          state_d = ST_RD;
        end
        run_d  = '0;
        idle_d = '0;
      end
      ST_WR, ST_RD: begin
        if (accept && (run_q != RUN_MAX)) begin
          runNext = run_q + RUN_W'(1);
        end
        run_d  = runNext;
        idle_d = ownEn ? '0 : idle_q + IDLE_W'(1);
        if (!(ownEn && !app_rdy)) begin
          if (peerEn && ((runNext == RUN_MAX) || ((idle_q == IDLE_LAST) && !ownEn))) begin
            state_d  = ownerWr ? ST_RD : ST_WR;
            lastRd_d = !ownerWr;
            run_d    = '0;
            idle_d   = '0;
          end else if (!ownEn && !peerEn && (idle_q == IDLE_LAST)) begin
            state_d  = ST_IDLE;
            lastRd_d = !ownerWr;
            run_d    = '0;
            idle_d   = '0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        run_d   = '0;
        idle_d  = '0;
      end
    endcase
  end

`ifdef DDR3_ARB_STATS_EN
  logic [CNT_W-1:0] wrCnt_q, rdCnt_q, switchCnt_q;
  logic             handover;

  assign handover = ((state_q == ST_WR) && (state_d == ST_RD)) ||
                    ((state_q == ST_RD) && (state_d == ST_WR));

  always_ff @(posedge clk) begin
    if (reset) begin
      wrCnt_q     <= '0;
      rdCnt_q     <= '0;
      switchCnt_q <= '0;
    end else begin
      if (grant_wr && accept) wrCnt_q <= wrCnt_q + CNT_W'(1);
      if (grant_rd && accept) rdCnt_q <= rdCnt_q + CNT_W'(1);
      if (handover) switchCnt_q <= switchCnt_q + CNT_W'(1);
    end
  end

  assign wr_cmd_cnt = wrCnt_q;
  assign rd_cmd_cnt = rdCnt_q;
  assign switch_cnt = switchCnt_q;
`else
  assign wr_cmd_cnt = '0;
  assign rd_cmd_cnt = '0;
  assign switch_cnt = '0;
`endif

endmodule

// File: tb/tb_ddr3_cmd_arbiter.sv
// Directed self-checking bench for ddr3_cmd_arbiter (MAX_RUN=4, HOLD=4).
// Counter expectations follow DDR3_ARB_STATS_EN: real counts when defined, zero otherwise.
module tb_ddr3_cmd_arbiter;
  localparam int ADDR_W  = 26;
  localparam int CNT_W   = 32;
  localparam int MAX_RUN = 4;
  localparam int HOLD    = 4;
`ifdef DDR3_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              wr_app_en, rd_app_en, app_rdy;
  logic [ADDR_W-1:0] wr_app_addr, rd_app_addr;
  logic              wr_app_rdy, rd_app_rdy, app_en, grant_wr, grant_rd;
  logic [2:0]        app_cmd;
  logic [ADDR_W-1:0] app_addr;
  logic [CNT_W-1:0]  wr_cmd_cnt, rd_cmd_cnt, switch_cnt;

  int checks = 0;
  int errors = 0;

  ddr3_cmd_arbiter #(
    .ADDR_W(ADDR_W), .MAX_RUN(MAX_RUN), .HOLD(HOLD), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .wr_app_en(wr_app_en), .wr_app_addr(wr_app_addr), .wr_app_rdy(wr_app_rdy),
    .rd_app_en(rd_app_en), .rd_app_addr(rd_app_addr), .rd_app_rdy(rd_app_rdy),
    .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr), .app_rdy(app_rdy),
    .grant_wr(grant_wr), .grant_rd(grant_rd),
    .wr_cmd_cnt(wr_cmd_cnt), .rd_cmd_cnt(rd_cmd_cnt), .switch_cnt(switch_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] expCnt(input int n);
    return STATS ? 32'(n) : 32'd0;
  endfunction

  // Starts a new cycle: waits for the edge, drives inputs, then lets combinational outputs settle.
  task automatic applyStimulus(input logic wrEn, input logic [ADDR_W-1:0] wrAddr,
                               input logic rdEn, input logic [ADDR_W-1:0] rdAddr,
                               input logic rdy);
    @(posedge clk);
    #2;
    wr_app_en   = wrEn;
    wr_app_addr = wrAddr;
    rd_app_en   = rdEn;
    rd_app_addr = rdAddr;
    app_rdy     = rdy;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic doReset(input string tag);
    reset = 1'b1;
    repeat (3) applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
    checkOutput({tag, "_grant_wr"}, 32'(grant_wr), 32'd0);
    checkOutput({tag, "_grant_rd"}, 32'(grant_rd), 32'd0);
    checkOutput({tag, "_app_en"}, 32'(app_en), 32'd0);
    checkOutput({tag, "_wr_rdy"}, 32'(wr_app_rdy), 32'd0);
    checkOutput({tag, "_rd_rdy"}, 32'(rd_app_rdy), 32'd0);
    checkOutput({tag, "_wr_cnt"}, wr_cmd_cnt, 32'd0);
    checkOutput({tag, "_rd_cnt"}, rd_cmd_cnt, 32'd0);
    checkOutput({tag, "_sw_cnt"}, switch_cnt, 32'd0);
    reset = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    wr_app_en   = 1'b0;
    rd_app_en   = 1'b0;
    app_rdy     = 1'b0;
    wr_app_addr = '0;
    rd_app_addr = '0;
    $display("[TB] start");

    doReset("rst");

    // Write only: granted one cycle after the request, nine accepts in ten cycles.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, ADDR_W'(8 + i), 1'b0, '0, 1'b1);
      if (i == 0) begin
        checkOutput("wo_grant_first", 32'(grant_wr), 32'd0);
        checkOutput("wo_en_first", 32'(app_en), 32'd0);
      end else begin
        checkOutput("wo_grant", 32'(grant_wr), 32'd1);
        checkOutput("wo_cmd", 32'(app_cmd), 32'd0);
        checkOutput("wo_addr", 32'(app_addr), 32'(8 + i));
        checkOutput("wo_wr_rdy", 32'(wr_app_rdy), 32'd1);
        checkOutput("wo_rd_rdy", 32'(rd_app_rdy), 32'd0);
      end
    end

    // Idle release: owner stays WR for four idle cycles, then IDLE.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
      if (i == 0) checkOutput("wo_wr_cnt", wr_cmd_cnt, expCnt(9));
      checkOutput("hold_grant", 32'(grant_wr), 32'd1);
      checkOutput("hold_en", 32'(app_en), 32'd0);
    end
    applyStimulus(1'b0, '0, 1'b1, ADDR_W'('h100), 1'b1);
    checkOutput("rel_grant_wr", 32'(grant_wr), 32'd0);
    checkOutput("rel_grant_rd", 32'(grant_rd), 32'd0);
    checkOutput("rel_en", 32'(app_en), 32'd0);
    applyStimulus(1'b0, '0, 1'b1, ADDR_W'('h100), 1'b1);
    checkOutput("rd_grant", 32'(grant_rd), 32'd1);
    checkOutput("rd_cmd", 32'(app_cmd), 32'd1);
    checkOutput("rd_addr", 32'(app_addr), 32'h100);
    checkOutput("rd_rdy", 32'(rd_app_rdy), 32'd1);
    checkOutput("rd_wr_rdy", 32'(wr_app_rdy), 32'd0);
    applyStimulus(1'b0, '0, 1'b1, ADDR_W'('h101), 1'b1);
    checkOutput("rd_grant2", 32'(grant_rd), 32'd1);
    checkOutput("rd_cnt1", rd_cmd_cnt, expCnt(1));

    // Reset mid-run: the command presented at the reset edge must not be counted.
    reset = 1'b1;
    applyStimulus(1'b0, '0, 1'b1, ADDR_W'('h102), 1'b1);
    checkOutput("mid_en", 32'(app_en), 32'd0);
    checkOutput("mid_rd_rdy", 32'(rd_app_rdy), 32'd0);
    checkOutput("mid_grant_rd", 32'(grant_rd), 32'd0);
    checkOutput("mid_rd_cnt", rd_cmd_cnt, 32'd0);
    doReset("rst2");

    // Run limit: both requesting, 4-accept runs alternating WR, RD, WR, then RD again.
    for (int u = 0; u < 14; u++) begin
      applyStimulus(1'b1, ADDR_W'('h20), 1'b1, ADDR_W'('h40), 1'b1);
      if (u == 0) begin
        checkOutput("rl_grant_wr0", 32'(grant_wr), 32'd0);
        checkOutput("rl_grant_rd0", 32'(grant_rd), 32'd0);
      end else if ((((u - 1) / 4) % 2) == 0) begin
        checkOutput("rl_grant_wr", 32'(grant_wr), 32'd1);
        checkOutput("rl_cmd_wr", 32'(app_cmd), 32'd0);
        checkOutput("rl_addr_wr", 32'(app_addr), 32'h20);
      end else begin
        checkOutput("rl_grant_rd", 32'(grant_rd), 32'd1);
        checkOutput("rl_cmd_rd", 32'(app_cmd), 32'd1);
        checkOutput("rl_addr_rd", 32'(app_addr), 32'h40);
      end
      if (u == 5) checkOutput("rl_sw1", switch_cnt, expCnt(1));
      if (u == 9) checkOutput("rl_sw2", switch_cnt, expCnt(2));
      if (u == 13) begin
        checkOutput("rl_sw3", switch_cnt, expCnt(3));
        checkOutput("rl_wr_cnt", wr_cmd_cnt, expCnt(8));
        checkOutput("rl_rd_cnt", rd_cmd_cnt, expCnt(4));
      end
    end
    doReset("rst3");

    // Backpressure: a held write keeps the grant until it is accepted.
    applyStimulus(1'b1, ADDR_W'('h55), 1'b1, ADDR_W'('h66), 1'b0);
    checkOutput("bp_grant0", 32'(grant_wr), 32'd0);
    for (int v = 0; v < 20; v++) begin
      applyStimulus(1'b1, ADDR_W'('h55), 1'b1, ADDR_W'('h66), 1'b0);
      checkOutput("bp_grant", 32'(grant_wr), 32'd1);
      checkOutput("bp_addr", 32'(app_addr), 32'h55);
      checkOutput("bp_wr_rdy", 32'(wr_app_rdy), 32'd0);
      checkOutput("bp_rd_rdy", 32'(rd_app_rdy), 32'd0);
    end
    for (int v = 0; v < 4; v++) begin
      applyStimulus(1'b1, ADDR_W'('h55), 1'b1, ADDR_W'('h66), 1'b1);
      checkOutput("bp_acc_grant", 32'(grant_wr), 32'd1);
      checkOutput("bp_acc_rdy", 32'(wr_app_rdy), 32'd1);
      if (v == 0) checkOutput("bp_sw0", switch_cnt, 32'd0);
    end
    applyStimulus(1'b1, ADDR_W'('h55), 1'b1, ADDR_W'('h66), 1'b1);
    checkOutput("bp_sw_grant", 32'(grant_rd), 32'd1);
    checkOutput("bp_sw_addr", 32'(app_addr), 32'h66);
    checkOutput("bp_sw_cnt", switch_cnt, expCnt(1));
    checkOutput("bp_wr_cnt", wr_cmd_cnt, expCnt(4));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
